// File: rtl/nn_result_uart_tx.sv
// UART (8N1, LSB first) report transmitter for the two NN outputs.
// On an accepted start it snapshots a3_1/a3_2 and sends HEADER, a3_1, a3_2 (big-endian bytes) and an XOR checksum.
module nn_result_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter logic [7:0]  HEADER       = 8'hA5
) (
  input  logic        clk,
  input  logic        res,
  input  logic        start,
  input  logic [15:0] a3_1,
  input  logic [15:0] a3_2,
  output logic        txd,
  output logic        busy,
  output logic        done
);

  localparam int unsigned BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [2:0] LAST_BYTE = 3'd5;
  localparam logic [2:0] LAST_BIT  = 3'd7;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START_BIT = 2'd1,
    DATA_BITS = 2'd2,
    STOP_BIT  = 2'd3
  } state_t;

  state_t        state, state_next;
  logic [BW-1:0] baud, baud_next;
  logic [2:0]    bit_cnt, bit_cnt_next;
  logic [2:0]    byte_idx, byte_idx_next;
  logic [15:0]   snap_1, snap_2;
  logic [7:0]    chk, cur_byte;
  logic          bit_end, accept;
  logic          txd_next, done_next;

  assign bit_end = (baud == BAUD_LAST);
  assign accept  = (state == IDLE) && start;
  assign chk     = snap_1[15:8] ^ snap_1[7:0] ^ snap_2[15:8] ^ snap_2[7:0];

  always_comb begin
    cur_byte = HEADER;
    case (byte_idx)
      3'd0:    cur_byte = HEADER;
      3'd1:    cur_byte = snap_1[15:8];
      3'd2:    cur_byte = snap_1[7:0];
      3'd3:    cur_byte = snap_2[15:8];
      3'd4:    cur_byte = snap_2[7:0];
      3'd5:    cur_byte = chk;
      default: cur_byte = HEADER;
    endcase
  end

  always_comb begin
    state_next    = state;
    baud_next     = bit_end ? '0 : baud + 1'b1;
    bit_cnt_next  = bit_cnt;
    byte_idx_next = byte_idx;
    done_next     = 1'b0;
    case (state)
      IDLE: begin
        baud_next = '0;
        if (start) begin
          state_next    = START_BIT;
          byte_idx_next = '0;
          bit_cnt_next  = '0;
        end
      end
      START_BIT: begin
        if (bit_end) begin
          state_next   = DATA_BITS;
          bit_cnt_next = '0;
        end
      end
      DATA_BITS: begin
        if (bit_end) begin
          if (bit_cnt == LAST_BIT) state_next = STOP_BIT;
          else                     bit_cnt_next = bit_cnt + 1'b1;
        end
      end
      STOP_BIT: begin
        if (bit_end) begin
          if (byte_idx == LAST_BYTE) begin
            state_next = IDLE;
            done_next  = 1'b1;
          end else begin
            state_next    = START_BIT;
            byte_idx_next = byte_idx + 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // txd/busy are registered from the next-state view so they line up exactly
  // with the state they describe and never glitch.
  always_comb begin
    txd_next = 1'b1;
    case (state_next)
      START_BIT: txd_next = 1'b0;
      DATA_BITS: txd_next = cur_byte[bit_cnt_next];
      default:   txd_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state    <= IDLE;
      baud     <= '0;
      bit_cnt  <= '0;
      byte_idx <= '0;
      txd      <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_next;
      baud     <= baud_next;
      bit_cnt  <= bit_cnt_next;
      byte_idx <= byte_idx_next;
      txd      <= txd_next;
      busy     <= (state_next != IDLE);
      done     <= done_next;
    end
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      snap_1 <= '0;
      snap_2 <= '0;
    end else if (accept) begin
      snap_1 <= a3_1;
      snap_2 <= a3_2;
    end
  end

endmodule

// File: tb/tb_nn_result_uart_tx.sv
// Self-checking bench for nn_result_uart_tx: table of frames plus corner-case sequences.
module tb_nn_result_uart_tx;

  localparam int CPB   = 4;
  localparam int FRAME = 60 * CPB;

  logic        clk = 1'b0;
  logic        res = 1'b0;
  logic        start = 1'b0;
  logic [15:0] a3_1 = '0;
  logic [15:0] a3_2 = '0;
  logic        txd, busy, done;

  int vec  = 0;
  int miss = 0;

  logic line [FRAME];

  typedef struct {
    logic [15:0] a1;
    logic [15:0] a2;
    logic [47:0] exp;
  } vec_t;

  vec_t tbl [8];

  nn_result_uart_tx #(.CLKS_PER_BIT(CPB), .HEADER(8'hA5)) dut (
    .clk   (clk),
    .res   (res),
    .start (start),
    .a3_1  (a3_1),
    .a3_2  (a3_2),
    .txd   (txd),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    vec++;
    if (act !== req) begin
      miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Reference: frame bytes packed with byte k at [8k +: 8].
  function automatic logic [47:0] frame_of(input logic [15:0] x, input logic [15:0] y);
    logic [7:0] c;
    c = x[15:8] ^ x[7:0] ^ y[15:8] ^ y[7:0];
    return {c, y[7:0], y[15:8], x[7:0], x[15:8], 8'hA5};
  endfunction

  task automatic launch(input logic [15:0] x, input logic [15:0] y);
    @(posedge clk); #1;
    a3_1 = x; a3_2 = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic capture(input string name, input logic [47:0] exp);
    int busy_lo = 0;
    int done_hi = 0;
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      line[i] = txd;
      if (busy !== 1'b1) busy_lo++;
      if (done !== 1'b0) done_hi++;
    end
    check($sformatf("%s busy_low_cycles", name), busy_lo, 0);
    check($sformatf("%s early_done", name), done_hi, 0);
    for (int k = 0; k < 6; k++) begin
      logic [7:0] dec;
      logic       e;
      int         bad;
      bad = 0;
      dec = '0;
      for (int p = 0; p < 10; p++) begin
        if (p == 0)      e = 1'b0;
        else if (p == 9) e = 1'b1;
        else             e = exp[8*k + p - 1];
        for (int c = 0; c < CPB; c++)
          if (line[(k*10 + p)*CPB + c] !== e) bad++;
        if (p >= 1 && p <= 8) dec[p-1] = line[(k*10 + p)*CPB + CPB/2];
      end
      check($sformatf("%s byte%0d", name, k), dec, exp[8*k +: 8]);
      check($sformatf("%s byte%0d_waveform_errs", name, k), bad, 0);
    end
  endtask

  task automatic check_done(input string name);
    @(negedge clk);
    check($sformatf("%s done_cycle {done,busy,txd}", name), {done, busy, txd}, 3'b101);
  endtask

  task automatic idle_watch(input string name, input int n);
    int bad = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if ({txd, busy, done} !== 3'b100) bad++;
    end
    check($sformatf("%s idle_errs", name), bad, 0);
  endtask

  initial begin
    tbl[0] = '{16'h1234, 16'hFF00, 48'hD9_00_FF_34_12_A5};
    tbl[1] = '{16'h8000, 16'h0001, 48'h81_01_00_00_80_A5};
    for (int i = 2; i < 8; i++) begin
      tbl[i].a1  = 16'($urandom);
      tbl[i].a2  = 16'($urandom);
      tbl[i].exp = frame_of(tbl[i].a1, tbl[i].a2);
    end

    // Reset held for 5 cycles, then idle with start low.
    begin
      int bad = 0;
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        if ({txd, busy, done} !== 3'b100) bad++;
      end
      check("reset_hold_errs", bad, 0);
    end
    @(posedge clk); #1 res = 1'b1;
    idle_watch("post_reset", 10);

    // Basic frame plus explicit first-byte line bits.
    launch(tbl[0].a1, tbl[0].a2);
    capture("basic", tbl[0].exp);
    begin
      logic [9:0] fb;
      for (int p = 0; p < 10; p++) fb[p] = line[p*CPB + CPB/2];
      check("basic first_byte_line_bits", fb, 10'b1101001010);
    end
    check_done("basic");
    idle_watch("basic_after", 5);

    // Snapshot: input changes after acceptance must not leak into the frame.
    launch(16'h1234, 16'hFF00);
    fork
      capture("snapshot", 48'hD9_00_FF_34_12_A5);
      begin @(posedge clk); #1 a3_1 = 16'hBEEF; end
    join
    check_done("snapshot");
    idle_watch("snapshot_after", 3);

    // Start while busy is ignored, nothing queued.
    launch(16'h1234, 16'hFF00);
    fork
      capture("ignore", 48'hD9_00_FF_34_12_A5);
      begin
        repeat (50) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
      end
    join
    check_done("ignore");
    idle_watch("ignore_no_second_frame", 300);

    // Back-to-back: start in the done cycle.
    launch(tbl[0].a1, tbl[0].a2);
    capture("b2b_first", tbl[0].exp);
    @(posedge clk); #1;
    a3_1 = tbl[1].a1; a3_2 = tbl[1].a2; start = 1'b1;
    check_done("b2b_first");
    @(posedge clk); #1 start = 1'b0;
    capture("b2b_second", tbl[1].exp);
    check_done("b2b_second");
    idle_watch("b2b_after", 3);

    // Mid-frame reset during data bits of byte 3.
    launch(16'h5A5A, 16'hC3C3);
    repeat (130) @(negedge clk);
    #1 res = 1'b0;
    #1 check("midreset async {txd,busy,done}", {txd, busy, done}, 3'b100);
    idle_watch("midreset_hold", 3);
    @(posedge clk); #1 res = 1'b1;
    idle_watch("midreset_release", 20);
    launch(16'h0F0F, 16'h7001);
    capture("after_reset", frame_of(16'h0F0F, 16'h7001));
    check_done("after_reset");
    idle_watch("after_reset_idle", 3);

    // Table-driven frames (fixed + randomized entries).
    for (int i = 0; i < 8; i++) begin
      launch(tbl[i].a1, tbl[i].a2);
      capture($sformatf("tbl%0d", i), tbl[i].exp);
      check_done($sformatf("tbl%0d", i));
      idle_watch($sformatf("tbl%0d_after", i), 2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule

// File: doc/nn_result_uart_tx.md
Name: nn_result_uart_tx

Overview:
- Transmit-side report block for the Zybo NN top. Today the network's results leave the chip only as LED comparisons.
- On a start pulse, snapshots the two NN outputs a3_1 and a3_2 (16-bit signed, 00_0000.0000_0000_00 format).
- Serialises them to the host as a fixed 6-byte UART frame: 8N1, LSB first.
- Sits beside the LED comparison logic on the clk_p domain. Typical trigger is the rising edge of finish_updating or a debounced button pulse.

Parameters:
- CLKS_PER_BIT, 868: clock cycles per UART bit (100 MHz / 115200). Legal range is 2 or more.
- HEADER, 8'hA5: first byte of every frame.

Ports:
- clk  input  1  system clock (clk_p)
- res  input  1  asynchronous reset, active-low
- start  input  1  request pulse; sampled on rising clk edge
- a3_1  input  16  NN output 1; captured when start is accepted
- a3_2  input  16  NN output 2; captured when start is accepted
- txd  output  1  UART serial line; idle high
- busy  output  1  high while a frame is in progress
- done  output  1  single-cycle pulse when the frame completes

Behaviour:
- Reset (res=0, asynchronous):
  - txd=1, busy=0, done=0.
  - FSM goes to IDLE; bit counter, baud counter and byte index all clear to 0.
  - A reset mid-frame aborts the frame immediately: txd returns high, no done pulse, no partial resume after release.
- Start acceptance:
  - start=1 is accepted only at an edge where the FSM is in IDLE.
  - At the accepting edge the block latches a3_1 and a3_2 into internal registers. Later input changes do not affect the frame.
  - start while busy=1 is ignored, with no queuing.
- Frame order, 6 bytes:
  - HEADER
  - a3_1[15:8], a3_1[7:0]
  - a3_2[15:8], a3_2[7:0]
  - CHK = XOR of the four data bytes
- FSM states: IDLE, START_BIT, DATA_BITS, STOP_BIT.
  - IDLE -> START_BIT on accepted start; the byte index resets to 0.
  - START_BIT: txd=0 for CLKS_PER_BIT cycles, then -> DATA_BITS.
  - DATA_BITS: bits 0..7 of the current byte, LSB first, each held for CLKS_PER_BIT cycles. After bit 7 -> STOP_BIT.
  - STOP_BIT: txd=1 for CLKS_PER_BIT cycles. Then, if byte index < 5: increment the index and -> START_BIT with no idle gap. If byte index = 5: -> IDLE.
- Timing:
  - txd first goes low the cycle after the accepting edge.
  - Every bit lasts exactly CLKS_PER_BIT cycles.
  - The whole frame lasts 60*CLKS_PER_BIT cycles.
- busy rises the cycle after the accepting edge. It falls in the same cycle done pulses, i.e. the cycle after the final stop-bit period ends.
- done is high for exactly 1 cycle per completed frame.
- A start asserted in the same cycle busy falls is accepted, so back-to-back frames are possible with 1 idle-high cycle between them.
- The baud counter counts 0..CLKS_PER_BIT-1 and wraps. It is held at 0 in IDLE.
- txd is driven from a register, so it is glitch-free.
- Signed values are sent as raw two's-complement bits with no conversion.

Test Plan:
- Reset: hold res=0 for 5 cycles, release -> txd=1, busy=0, done=0 throughout, including with start held low.
- Basic frame, CLKS_PER_BIT=4, a3_1=16'h1234, a3_2=16'hFF00, 1-cycle start:
  - Decoded bytes must be A5,12,34,FF,00,D9.
  - First byte's line bits must be 0 (start), 1,0,1,0,0,1,0,1 (data), 1 (stop).
  - busy is high for exactly 240 cycles, then done pulses once.
- Snapshot: change a3_1 to 16'hBEEF one cycle after start -> frame still carries 12,34 and CHK=D9.
- Ignore while busy: pulse start again at cycle 50 of a frame -> exactly one frame and one done pulse; no second frame follows.
- Back-to-back: assert start in the done cycle with a3_1=16'h8000, a3_2=16'h0001 -> second frame A5,80,00,00,01,81 follows after 1 idle-high cycle.
- Mid-frame reset: drop res during the data bits of byte 3 -> txd=1 asynchronously, busy=0, no done. After release a new start yields a complete, correct frame.
